// File: rtl/rib_arbiter_ctrl.sv
// rib_arbiter_ctrl: registered round-robin arbiter and transaction sequencer for the RIB bus
// Ports: clk/rst (sync, active-low); m0..m3_req_i master requests; s_ready_i slave done;
//        grant_o mux select; grant_valid_o transaction in flight; ack_o one-hot completion;
//        err_o timeout flag with ack; hold_flag_o pipeline stall; busy_cnt_o wait-cycle debug count
module rib_arbiter_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             m0_req_i,
   input  logic             m1_req_i,
   input  logic             m2_req_i,
   input  logic             m3_req_i,
   input  logic             s_ready_i,
   output logic [1:0]       grant_o,
   output logic             grant_valid_o,
   output logic [3:0]       ack_o,
   output logic             err_o,
   output logic             hold_flag_o,
   output logic [CNT_W-1:0] busy_cnt_o
);
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
   state_t state, state_n;
   logic [3:0] req, ack_n;
   logic [1:0] last_grant, last_grant_n, grant_n, win;
   logic grant_valid_n, err_n;
   logic [CNT_W-1:0] cnt_n;
   assign req = {m3_req_i, m2_req_i, m1_req_i, m0_req_i};
   // master 1 (instruction fetch) alone never stalls the pipeline
   assign hold_flag_o = (m0_req_i | m2_req_i | m3_req_i) & ~(ack_o[0] | ack_o[2] | ack_o[3]);
   always_comb begin
      // scan farthest offset first so the nearest requester after last_grant wins
      win = last_grant;
      for (int i = 4; i >= 1; i--)
         if (req[last_grant + 2'(i)]) win = last_grant + 2'(i);
      state_n = state;
      grant_n = grant_o;
      grant_valid_n = grant_valid_o;
      ack_n = '0;
      err_n = 1'b0;
      cnt_n = busy_cnt_o;
      last_grant_n = last_grant;
      if (state == IDLE) begin
         // the ack cycle is a dead cycle: no back-to-back grant
         if (|req && ack_o == '0) begin
            state_n = BUSY;
            grant_n = win;
            grant_valid_n = 1'b1;
            cnt_n = '0;
         end
      end else if (!req[grant_o]) begin
         // withdrawal: no ack and the pointer stays put
         state_n = IDLE;
         grant_valid_n = 1'b0;
      end else if (s_ready_i || busy_cnt_o == CNT_MAX) begin
         state_n = IDLE;
         grant_valid_n = 1'b0;
         ack_n = 4'(1) << grant_o;
         err_n = !s_ready_i;
         last_grant_n = grant_o;
      end else begin
         cnt_n = busy_cnt_o + CNT_W'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         grant_o <= 2'd0;
         grant_valid_o <= 1'b0;
         ack_o <= '0;
         err_o <= 1'b0;
         busy_cnt_o <= '0;
         last_grant <= 2'd3;
      end else begin
         state <= state_n;
         grant_o <= grant_n;
         grant_valid_o <= grant_valid_n;
         ack_o <= ack_n;
         err_o <= err_n;
         busy_cnt_o <= cnt_n;
         last_grant <= last_grant_n;
      end
   end
endmodule

// File: tb/tb_rib_arbiter_ctrl.sv
// tb_rib_arbiter_ctrl: directed self-checking bench for rib_arbiter_ctrl
module tb_rib_arbiter_ctrl;
   logic clk, rst, m0, m1, m2, m3, s_ready;
   logic [1:0] grant;
   logic gv, err, hold;
   logic [3:0] ack;
   logic [7:0] cnt;
   int tests = 0, fails = 0;
   rib_arbiter_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0), .m1_req_i(m1), .m2_req_i(m2), .m3_req_i(m3),
      .s_ready_i(s_ready),
      .grant_o(grant), .grant_valid_o(gv), .ack_o(ack), .err_o(err),
      .hold_flag_o(hold), .busy_cnt_o(cnt)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      rst = 1'b0; m0 = 0; m1 = 0; m2 = 0; m3 = 0; s_ready = 0;
      tick; tick;
      rst = 1'b1;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_gv", 32'(gv), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_cnt", 32'(cnt), 0);
      chk("rst_hold", 32'(hold), 0);
      // single m1 transaction, minimum latency
      m1 = 1;
      tick;
      chk("m1_gv", 32'(gv), 1);
      chk("m1_grant", 32'(grant), 1);
      chk("m1_hold", 32'(hold), 0);
      s_ready = 1;
      tick;
      chk("m1_ack", 32'(ack), 32'h2);
      chk("m1_gv_fall", 32'(gv), 0);
      chk("m1_err", 32'(err), 0);
      chk("m1_hold_ack", 32'(hold), 0);
      m1 = 0; s_ready = 0;
      tick;
      chk("m1_idle_ack", 32'(ack), 0);
      chk("m1_idle_gv", 32'(gv), 0);
      // round robin with all four requesting
      rst = 0; tick; rst = 1;
      m0 = 1; m1 = 1; m2 = 1; m3 = 1; s_ready = 1;
      for (int k = 0; k < 5; k++) begin
         tick;
         chk("rr_gv", 32'(gv), 1);
         chk("rr_grant", 32'(grant), 32'(k % 4));
         tick;
         chk("rr_ack", 32'(ack), 32'(1) << (k % 4));
         chk("rr_gv_fall", 32'(gv), 0);
         tick;
         chk("rr_gap_gv", 32'(gv), 0);
         chk("rr_gap_ack", 32'(ack), 0);
      end
      m0 = 0; m1 = 0; m2 = 0; m3 = 0; s_ready = 0;
      tick;
      // m2 timeout (pointer now 0)
      m2 = 1;
      tick;
      chk("to_grant", 32'(grant), 2);
      chk("to_cnt0", 32'(cnt), 0);
      for (int k = 0; k < 15; k++) tick;
      chk("to_cnt15", 32'(cnt), 15);
      chk("to_gv", 32'(gv), 1);
      chk("to_noack", 32'(ack), 0);
      chk("to_hold", 32'(hold), 1);
      tick;
      chk("to_ack", 32'(ack), 32'h4);
      chk("to_err", 32'(err), 1);
      chk("to_gv_fall", 32'(gv), 0);
      chk("to_nowrap", 32'(cnt), 15);
      chk("to_hold_ack", 32'(hold), 0);
      m2 = 0;
      tick;
      chk("to_err_pulse", 32'(err), 0);
      chk("to_ack_pulse", 32'(ack), 0);
      // m3 withdrawal (pointer now 2)
      m3 = 1;
      tick;
      chk("wd_grant", 32'(grant), 3);
      tick; tick;
      chk("wd_cnt", 32'(cnt), 2);
      m3 = 0;
      tick;
      chk("wd_gv", 32'(gv), 0);
      chk("wd_ack", 32'(ack), 0);
      m3 = 1; m0 = 1;
      tick;
      chk("wd_regrant", 32'(grant), 3);
      chk("wd_regv", 32'(gv), 1);
      s_ready = 1;
      tick;
      chk("wd_ack3", 32'(ack), 32'h8);
      m3 = 0; m0 = 0; s_ready = 0;
      tick;
      // reset in BUSY overrides s_ready
      m1 = 1;
      tick;
      chk("rb_gv", 32'(gv), 1);
      rst = 0; s_ready = 1;
      tick;
      chk("rb_ack", 32'(ack), 0);
      chk("rb_gv0", 32'(gv), 0);
      chk("rb_grant", 32'(grant), 0);
      chk("rb_err", 32'(err), 0);
      rst = 1; m1 = 0; s_ready = 0;
      tick;
      chk("rb_after_ack", 32'(ack), 0);
      // m0 and m1: hold flag and stable grant over wait cycles
      m0 = 1; m1 = 1;
      #1;
      chk("hf_hold_req", 32'(hold), 1);
      tick;
      chk("hf_grant", 32'(grant), 0);
      chk("hf_hold", 32'(hold), 1);
      for (int k = 0; k < 5; k++) begin
         tick;
         chk("hf_wait_grant", 32'(grant), 0);
         chk("hf_wait_gv", 32'(gv), 1);
         chk("hf_wait_hold", 32'(hold), 1);
      end
      chk("hf_cnt", 32'(cnt), 5);
      s_ready = 1;
      tick;
      chk("hf_ack", 32'(ack), 32'h1);
      chk("hf_hold_ack", 32'(hold), 0);
      s_ready = 0;
      tick;
      chk("hf_hold_back", 32'(hold), 1);
      tick;
      chk("hf_next_grant", 32'(grant), 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
